// File: rtl/gps_pkg.sv
// Shared constants, state encoding and helpers for the GPS sample packer.
// A word holds 16 two-bit {sign,mag} samples; counters saturate at all-ones.
package gps_pkg;
  localparam int SAMPLES_PER_WORD = 16;
  localparam int BITS_PER_SAMPLE  = 2;
  localparam int WORD_W           = SAMPLES_PER_WORD * BITS_PER_SAMPLE;
  localparam int IDX_W            = $clog2(SAMPLES_PER_WORD);
  localparam int CNT_W            = 8;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SIGN = 2'd1,
    MAG  = 2'd2
  } state_e;

  typedef struct packed {
    logic clk;
    logic sync;
    logic data;
  } fe_bits_t;

  // A clear wins over the held value, but an increment in the same cycle still lands.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic inc, input logic clr);
    if (clr) return {{(CNT_W-1){1'b0}}, inc};
    if (inc && (c != '1)) return c + 1'b1;
    return c;
  endfunction
endpackage

// File: rtl/gps_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; dout always shows the oldest entry.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module gps_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         wr_en, rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/gps_sample_packer.sv
// Synchronizes a serial GPS front-end, frames {sign,mag} samples and packs
// 16 of them per 32-bit word into a FWFT FIFO with drop/framing status.
module gps_sample_packer
  import gps_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              enable,
  input  logic              gps_rec_clk,
  input  logic              gps_rec_sync,
  input  logic              gps_rec_data,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  input  logic              clr_status,
  output logic              overflow,
  output logic [CNT_W-1:0]  drop_count,
  output logic [CNT_W-1:0]  frame_err_count
);
  localparam int FE_W = $bits(fe_bits_t);

  logic [SYNC_STAGES-1:0][FE_W-1:0] sync_pipe;
  fe_bits_t fe;
  logic     clk_q, strobe;

  assign fe     = sync_pipe[SYNC_STAGES-1];
  assign strobe = fe.clk & ~clk_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_pipe <= '0;
      clk_q     <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], {gps_rec_clk, gps_rec_sync, gps_rec_data}};
      clk_q     <= fe.clk;
    end
  end

  state_e state, nstate;
  logic   ld_sign, ld_mag, clr_word, ferr;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= HUNT;
    else            state <= nstate;
  end

  always_comb begin
    nstate   = state;
    ld_sign  = 1'b0;
    ld_mag   = 1'b0;
    clr_word = 1'b0;
    ferr     = 1'b0;
    if (!enable) begin
      nstate   = HUNT;
      clr_word = 1'b1;
    end else if (strobe) begin
      unique case (state)
        HUNT: if (fe.sync) begin ld_sign = 1'b1; nstate = MAG; end
        SIGN: begin
          if (fe.sync) begin
            ld_sign = 1'b1;
            nstate  = MAG;
          end else begin
            ferr     = 1'b1;
            clr_word = 1'b1;
            nstate   = HUNT;
          end
        end
        MAG: begin
          if (!fe.sync) begin
            ld_mag = 1'b1;
            nstate = SIGN;
          end else begin
            // Unexpected sync restarts the word with this bit as sample 0's sign.
            ferr     = 1'b1;
            clr_word = 1'b1;
            ld_sign  = 1'b1;
          end
        end
        default: nstate = HUNT;
      endcase
    end
  end

  logic [WORD_W-1:0] word, push_word, sign_bit, mag_bit;
  logic [IDX_W-1:0]  idx;
  logic              push_pend, last_sample;

  assign sign_bit    = WORD_W'(fe.data) << {idx, 1'b1};
  assign mag_bit     = WORD_W'(fe.data) << {idx, 1'b0};
  assign last_sample = (idx == IDX_W'(SAMPLES_PER_WORD - 1));

  // Partial word bits start at zero, so samples are OR-ed into place.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      word      <= '0;
      push_word <= '0;
      idx       <= '0;
      push_pend <= 1'b0;
    end else begin
      push_pend <= 1'b0;
      if (clr_word) begin
        idx  <= '0;
        word <= ld_sign ? (WORD_W'(fe.data) << 1) : '0;
      end else if (ld_sign) begin
        word <= word | sign_bit;
      end else if (ld_mag) begin
        if (last_sample) begin
          push_word <= word | mag_bit;
          push_pend <= 1'b1;
          word      <= '0;
          idx       <= '0;
        end else begin
          word <= word | mag_bit;
          idx  <= idx + 1'b1;
        end
      end
    end
  end

  logic full, empty, pop, drop;

  gps_sync_fifo #(.DEPTH(FIFO_DEPTH), .W(WORD_W)) u_fifo (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .push  (push_pend),
    .pop   (word_ready),
    .din   (push_word),
    .dout  (word_data),
    .full  (full),
    .empty (empty)
  );

  assign word_valid = ~empty;
  assign pop        = word_valid & word_ready;
  assign drop       = push_pend & full & ~pop;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      overflow        <= 1'b0;
      drop_count      <= '0;
      frame_err_count <= '0;
    end else begin
      overflow        <= clr_status ? drop : (overflow | drop);
      drop_count      <= sat_inc(drop_count, drop, clr_status);
      frame_err_count <= sat_inc(frame_err_count, ferr, clr_status);
    end
  end
endmodule

// File: tb/tb_gps_sample_packer.sv
// Random and directed front-end bit streams checked against a sample-list
// reference model of the framing rules, the output FIFO and the status counters.
module tb_gps_sample_packer;
  localparam int DEPTH = 4;

  logic        sys_clk = 0, sys_rst_n = 1, enable = 0;
  logic        gps_rec_clk = 0, gps_rec_sync = 0, gps_rec_data = 0;
  logic        word_ready = 1, clr_status = 0;
  logic [31:0] word_data;
  logic        word_valid, overflow;
  logic [7:0]  drop_count, frame_err_count;

  int total = 0, bad = 0;

  gps_sample_packer #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .enable(enable),
    .gps_rec_clk(gps_rec_clk), .gps_rec_sync(gps_rec_sync), .gps_rec_data(gps_rec_data),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .clr_status(clr_status), .overflow(overflow), .drop_count(drop_count),
    .frame_err_count(frame_err_count)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: received samples as a list, expected words as a queue.
  logic [31:0] exp_q[$];
  logic [1:0]  samp_q[$];
  bit          m_hunt = 1, m_have_sign = 0, m_sign = 0, m_ovf = 0;
  int          m_ferr = 0, m_drop = 0;
  logic [31:0] last_word = 0, mon_exp;
  int          rx_count = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic void model_push(input logic [31:0] w);
    if (!word_ready && exp_q.size() >= DEPTH) begin
      m_ovf  = 1;
      m_drop = (m_drop < 255) ? m_drop + 1 : 255;
    end else exp_q.push_back(w);
  endfunction

  function automatic void model_err();
    m_ferr = (m_ferr < 255) ? m_ferr + 1 : 255;
    samp_q.delete();
  endfunction

  function automatic void model_flush();
    samp_q.delete();
    m_hunt      = 1;
    m_have_sign = 0;
  endfunction

  function automatic void model_bit(input bit s, input bit d);
    logic [31:0] w;
    if (m_hunt) begin
      if (s) begin m_sign = d; m_hunt = 0; m_have_sign = 1; end
    end else if (m_have_sign) begin
      if (!s) begin
        samp_q.push_back({m_sign, d});
        m_have_sign = 0;
        if (samp_q.size() == 16) begin
          w = '0;
          for (int n = 0; n < 16; n++) w = w | (32'(samp_q[n]) << (2 * n));
          samp_q.delete();
          model_push(w);
        end
      end else begin
        model_err();
        m_sign = d;
      end
    end else begin
      if (s) begin m_sign = d; m_have_sign = 1; end
      else begin model_err(); m_hunt = 1; end
    end
  endfunction

  task automatic send_bit(input bit s, input bit d);
    @(posedge sys_clk); #1;
    gps_rec_sync = s;
    gps_rec_data = d;
    model_bit(s, d);
    repeat (3) @(posedge sys_clk);
    #1 gps_rec_clk = 1;
    repeat (4) @(posedge sys_clk);
    #1 gps_rec_clk = 0;
  endtask

  task automatic send_sample(input logic [1:0] smp);
    send_bit(1'b1, smp[1]);
    send_bit(1'b0, smp[0]);
  endtask

  task automatic send_word_random();
    for (int i = 0; i < 16; i++) send_sample(2'($urandom_range(0, 3)));
  endtask

  task automatic wait_drained(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge sys_clk);
      n++;
    end
    #1;
    check(tag, 32'(exp_q.size()), 32'd0);
    check({tag, "_valid"}, 32'(word_valid), 32'd0);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_ferr"}, 32'(frame_err_count), 32'(m_ferr));
    check({tag, "_drop"}, 32'(drop_count), 32'(m_drop));
    check({tag, "_ovf"},  32'(overflow), 32'(m_ovf));
  endtask

  task automatic pulse_clr();
    @(posedge sys_clk); #1 clr_status = 1;
    @(posedge sys_clk); #1 clr_status = 0;
    m_ferr = 0; m_drop = 0; m_ovf = 0;
  endtask

  // Every handshake seen here is the word popped at the following rising edge.
  always @(negedge sys_clk) begin
    if (sys_rst_n && word_valid && word_ready) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL word_extra: observed=%h expected=none", word_data);
      end
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        check("word_data", word_data, mon_exp);
        last_word = word_data;
        rx_count++;
      end
    end
  end

  initial begin
    int rx0;
    bit y, m;

    #2 sys_rst_n = 0;
    #1;
    check("rst_valid", 32'(word_valid), 32'd0);
    check("rst_data", word_data, 32'd0);
    check_status("rst");
    repeat (3) @(posedge sys_clk);
    #1 sys_rst_n = 1;
    enable = 1;

    // All-01 samples give the alternating pattern word.
    for (int i = 0; i < 16; i++) send_sample(2'b01);
    wait_drained("w55");
    check("w55_value", last_word, 32'h5555_5555);
    check_status("w55");

    for (int w = 0; w < 3; w++) send_word_random();
    wait_drained("rand");
    check_status("rand");

    // Sync where sample 2's magnitude belongs: that bit restarts the word.
    send_sample(2'($urandom_range(0, 3)));
    send_sample(2'($urandom_range(0, 3)));
    send_bit(1'b1, 1'($urandom_range(0, 1)));
    y = 1'($urandom_range(0, 1));
    m = 1'($urandom_range(0, 1));
    send_bit(1'b1, y);
    send_bit(1'b0, m);
    for (int i = 0; i < 15; i++) send_sample(2'($urandom_range(0, 3)));
    wait_drained("mag_err");
    check("mag_err_head", 32'(last_word[1:0]), 32'({y, m}));
    check_status("mag_err");

    // Missing sync on a sign bit drops to hunting; the next unsynced bit is ignored.
    send_sample(2'($urandom_range(0, 3)));
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    send_word_random();
    wait_drained("sign_err");
    check_status("sign_err");

    pulse_clr();
    #1 check_status("clr1");

    // Five words into a four-deep FIFO with the consumer stalled.
    word_ready = 0;
    for (int w = 0; w < 5; w++) send_word_random();
    repeat (5) @(posedge sys_clk);
    #1;
    check("ovf_valid", 32'(word_valid), 32'd1);
    check("ovf_head", word_data, exp_q[0]);
    check("ovf_held", 32'(exp_q.size()), 32'(DEPTH));
    check_status("ovf");
    word_ready = 1;
    wait_drained("ovf_drain");

    // Disable mid-word, then a clean word built only from new samples.
    rx0 = rx_count;
    for (int i = 0; i < 7; i++) send_sample(2'($urandom_range(0, 3)));
    @(posedge sys_clk); #1 enable = 0;
    model_flush();
    repeat (3) @(posedge sys_clk);
    #1 enable = 1;
    send_word_random();
    wait_drained("enable");
    check("enable_words", 32'(rx_count - rx0), 32'd1);
    check_status("enable");

    // Reset with a stored word, a raised error count and a partial word.
    word_ready = 0;
    send_word_random();
    send_sample(2'($urandom_range(0, 3)));
    send_bit(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) send_sample(2'($urandom_range(0, 3)));
    @(posedge sys_clk); #1 sys_rst_n = 0;
    #1;
    check("rrst_valid", 32'(word_valid), 32'd0);
    check("rrst_data", word_data, 32'd0);
    exp_q.delete();
    model_flush();
    m_ferr = 0; m_drop = 0; m_ovf = 0;
    check_status("rrst");
    repeat (2) @(posedge sys_clk);
    #1 sys_rst_n = 1;
    word_ready = 1;
    send_bit(1'b0, 1'b1);
    send_word_random();
    wait_drained("post_rst");
    check_status("post_rst");

    // 301 consecutive sync bits: 300 framing errors, count pinned at 255.
    for (int i = 0; i < 301; i++) send_bit(1'b1, 1'($urandom_range(0, 1)));
    check_status("sat");
    check("sat_value", 32'(frame_err_count), 32'd255);
    pulse_clr();
    #1 check_status("sat_clr");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
